rf_ctrl: RTL and testbench

Command sequencer that drives the read and write ports of the 32×32 register file: the initiator side of the `rf_raddr_*` / `rf_rdata_*` / `rf_we` interface. It accepts one command at a time over a valid/ready handshake. It reads up to two source registers, computes a 32-bit result and writes it back to a destination register. It then reports the result on a one-cycle response strobe. It sits between the board-level command source (switch/UART decoder) and the register file.

---
 rtl/rf_ctrl_pkg.sv | 28 ++
 rtl/rf_ctrl_alu.sv | 31 +++
 rtl/rf_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rf_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and widths for the register-file command sequencer.
// Opcode and FSM state encodings live here so the ALU, the top and any checkers agree.
package rf_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;

  typedef enum logic [2:0] {
    OP_POKE = 3'd0,
    OP_PEEK = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_SLL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rf_ctrl_alu.sv
// Combinational result unit: maps an opcode and two operands (or the immediate)
// to a 32-bit result, modulo 2^32, with no flags.
module rf_ctrl_alu
  import rf_ctrl_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] result_o
);

  op_e op;
  assign op = op_e'(op_i);

  always_comb begin
    result_o = '0;
    case (op)
      OP_POKE: result_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
      OP_PEEK: result_o = a_i;
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << b_i[4:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/rf_ctrl.sv
// Command sequencer driving the register-file ports: accept, read operands,
// execute, write back, then strobe the response.
module rf_ctrl
  import rf_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [REG_AW-1:0]    cmd_rd,
  input  logic [REG_AW-1:0]    cmd_rs1,
  input  logic [REG_AW-1:0]    cmd_rs2,
  input  logic [IMM_W-1:0]     cmd_imm,
  output logic [REG_AW-1:0]    rf_raddr_a,
  input  logic [DATA_W-1:0]    rf_rdata_a,
  output logic [REG_AW-1:0]    rf_raddr_b,
  input  logic [DATA_W-1:0]    rf_rdata_b,
  output logic [REG_AW-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 rf_we,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 busy,
  output logic [15:0]          cmd_count
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE and never during reset.

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [REG_AW-1:0]   raddr_a_q, raddr_a_d;
  logic [REG_AW-1:0]   raddr_b_q, raddr_b_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]         count_q, count_d;
  logic [DATA_W-1:0]   alu_result;
  logic                accept;

  rf_ctrl_alu u_alu (
    .op_i     (op_q),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .imm_i    (imm_q),
    .result_o (alu_result)
  );

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    raddr_a_d   = raddr_a_q;
    raddr_b_d   = raddr_b_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = op_e'(cmd_op);
          rd_d      = cmd_rd;
          imm_d     = cmd_imm;
          raddr_a_d = cmd_rs1;
          raddr_b_d = cmd_rs2;
          // POKE needs no operands, so its result is known at accept time.
          if (op_e'(cmd_op) == OP_POKE) begin
            result_d = {{(DATA_W-IMM_W){1'b0}}, cmd_imm};
            state_d  = WRITE;
          end else begin
            state_d  = READ;
          end
        end
      end
      READ: begin
        opa_d   = rf_rdata_a;
        opb_d   = rf_rdata_b;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = (op_q == OP_PEEK) ? DONE : WRITE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Write-port and response registers load on entry to their cycle and then hold.
    if (state_d == WRITE) begin
      we_d    = (rd_d != '0);
      waddr_d = rd_d;
      wdata_d = result_d;
    end
    if (state_d == DONE) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = result_d;
      count_d     = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_POKE;
      rd_q        <= '0;
      imm_q       <= '0;
      raddr_a_q   <= '0;
      raddr_b_q   <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      raddr_a_q   <= raddr_a_d;
      raddr_b_q   <= raddr_b_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      count_q     <= count_d;
    end
  end

  assign rf_raddr_a = raddr_a_q;
  assign rf_raddr_b = raddr_b_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign rf_we      = we_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != IDLE);
  assign cmd_count  = count_q;

endmodule

// File: tb/tb_rf_ctrl.sv
// Directed bench for rf_ctrl: a behavioural register file, a command driver that
// queues hand-computed write/response expectations, and a negedge monitor that checks them.
module tb_rf_ctrl;
  import rf_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] cmd_imm;
  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic [15:0] cmd_count;

  rf_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .rf_raddr_a (rf_raddr_a),
    .rf_rdata_a (rf_rdata_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_b (rf_rdata_b),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_we      (rf_we),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .cmd_count  (cmd_count)
  );

  // ---------------- clock / reset / register file ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;
  assign rf_rdata_a = (rf_raddr_a == 5'd0) ? 32'd0 : regs[rf_raddr_a];
  assign rf_rdata_b = (rf_raddr_b == 5'd0) ? 32'd0 : regs[rf_raddr_b];

  // ---------------- scoreboard state ----------------
  // write entry {cycle, addr, data}; response entry {cycle, count, data}
  logic [68:0] exp_wr_q [$];
  logic [79:0] exp_q [$];
  int          applied = 0;
  int          fails = 0;
  logic [15:0] exp_count = '0;
  logic [31:0] last_rsp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [4:0] rd,
                          input logic [31:0] res, input int t);
    int t_we, t_rsp;
    exp_count = exp_count + 16'd1;
    if (op == OP_POKE) begin
      t_we = t + 1; t_rsp = t + 2;
    end else if (op == OP_PEEK) begin
      t_we = -1; t_rsp = t + 3;
    end else begin
      t_we = t + 3; t_rsp = t + 4;
    end
    if (op != OP_PEEK && rd != 5'd0) exp_wr_q.push_back({32'(t_we), rd, res});
    exp_q.push_back({32'(t_rsp), exp_count, res});
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [15:0] imm,
                      input logic [31:0] res, input bit track);
    bit ok;
    ok = 0;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      applied++; fails++;
      $display("FAIL accept_timeout: op %0d never accepted within 50 cycles", op);
    end else if (track) begin
      push_exp(op, rd, res, cyc);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [68:0] ew;
    logic [79:0] er;
    if (reset) begin
      last_rsp = '0;
    end else begin
      if (busy == cmd_ready) begin
        fails++;
        $display("FAIL ready_busy: cyc %0d busy %0b cmd_ready %0b", cyc, busy, cmd_ready);
      end
      if (rf_we) begin
        applied++;
        if (exp_wr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: cyc %0d waddr %0d wdata 0x%08h", cyc, rf_waddr, rf_wdata);
        end else begin
          ew = exp_wr_q.pop_front();
          if ({32'(cyc), rf_waddr, rf_wdata} !== ew) begin
            fails++;
            $display("FAIL write: got cyc %0d addr %0d data 0x%08h, expected cyc %0d addr %0d data 0x%08h",
                     cyc, rf_waddr, rf_wdata, ew[68:37], ew[36:32], ew[31:0]);
          end
        end
      end
      if (rsp_valid) begin
        applied++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: cyc %0d data 0x%08h", cyc, rsp_data);
        end else begin
          er = exp_q.pop_front();
          if ({32'(cyc), cmd_count, rsp_data} !== er) begin
            fails++;
            $display("FAIL rsp: got cyc %0d count %0d data 0x%08h, expected cyc %0d count %0d data 0x%08h",
                     cyc, cmd_count, rsp_data, er[79:48], er[47:32], er[31:0]);
          end
        end
        last_rsp = rsp_data;
      end else if (rsp_data !== last_rsp) begin
        fails++;
        $display("FAIL rsp_hold: rsp_data 0x%08h changed from 0x%08h outside DONE", rsp_data, last_rsp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int accepts;
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    #1;
    check("ready_in_reset", 32'(cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(cmd_count), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;

    send(OP_POKE, 5'd5, 5'd0, 5'd0, 16'hBEEF, 32'h0000BEEF, 1);
    send(OP_POKE, 5'd1, 5'd0, 5'd0, 16'hFFFF, 32'h0000FFFF, 1);
    send(OP_POKE, 5'd2, 5'd0, 5'd0, 16'h0001, 32'h00000001, 1);
    send(OP_ADD,  5'd3, 5'd1, 5'd2, 16'h0000, 32'h00010000, 1);
    send(OP_SUB,  5'd4, 5'd2, 5'd1, 16'h0000, 32'hFFFF0002, 1);
    send(OP_POKE, 5'd7, 5'd0, 5'd0, 16'h0023, 32'h00000023, 1);
    send(OP_SLL,  5'd6, 5'd2, 5'd7, 16'h0000, 32'h00000008, 1);
    send(OP_PEEK, 5'd0, 5'd6, 5'd0, 16'h0000, 32'h00000008, 1);
    // rd = 0: the sum wraps to 2 and is reported but never written
    send(OP_ADD,  5'd0, 5'd3, 5'd4, 16'h0000, 32'h00000002, 1);
    send(OP_AND,  5'd8, 5'd1, 5'd4, 16'h0000, 32'h00000002, 1);
    send(OP_OR,   5'd9, 5'd1, 5'd4, 16'h0000, 32'hFFFFFFFF, 1);
    send(OP_XOR, 5'd10, 5'd1, 5'd4, 16'h0000, 32'hFFFFFFFD, 1);

    // valid held for 10 cycles on an idle block: POKE takes 3 cycles, so 4 accepts
    wait_idle();
    cmd_op = OP_POKE; cmd_rd = 5'd11; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = 16'h1234;
    cmd_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepts++;
        push_exp(OP_POKE, 5'd11, 32'h00001234, cyc);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("hold_accepts", 32'(accepts), 32'd4);

    // reset asserted mid-EXEC of an ADD: outputs clear at once, nothing completes
    wait_idle();
    send(OP_ADD, 5'd12, 5'd1, 5'd4, 16'h0000, 32'h0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_raddr", 32'({rf_raddr_a, rf_raddr_b}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    exp_count = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("dropped_no_write", regs[12], 32'd0);

    send(OP_POKE, 5'd13, 5'd0, 5'd0, 16'h00A5, 32'h000000A5, 1);
    send(OP_PEEK, 5'd0, 5'd13, 5'd0, 16'h0000, 32'h000000A5, 1);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && exp_wr_q.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    check("pending_rsp", 32'(exp_q.size()), 32'd0);
    check("pending_wr", 32'(exp_wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end

endmodule
